// File: rtl/irrigation_pkg.sv
// ---------------------------------------------------------------------------
// irrigation_pkg
// Shared types and helpers for the irrigation zone sequencer:
//   state_e     - sequencer FSM states (IDLE, SCAN, WATER, FAULT)
//   mode_e      - watering path chosen for one zone visit (DRIPPER/SPRINKLER)
//   ptrWidth    - width of a pointer/counter able to index n items (min 1)
//   rawConflict - undebounced tank-sensor plausibility check
// ---------------------------------------------------------------------------
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WATER = 2'd2,
        FAULT = 2'd3
    } state_e;

    typedef enum logic {
        DRIPPER   = 1'b0,
        SPRINKLER = 1'b1
    } mode_e;

    // A single zone still needs a one-bit pointer so the port never collapses.
    function automatic int ptrWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // The level sensors are stacked, so a higher mark can never read wet
    // while a lower one reads dry.
    function automatic logic rawConflict(input logic low, input logic mid, input logic high);
        return (high & ~mid) | (mid & ~low);
    endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// ---------------------------------------------------------------------------
// sensor_debouncer
// Turns a noisy raw condition into a stable flag. The flag is raised once the
// raw input has been seen high for DEBOUNCE consecutive cycles and drops as
// soon as a clean sample clears the run counter.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   raw_i    in  undebounced condition
//   stable_o out debounced condition
// ---------------------------------------------------------------------------
module sensor_debouncer
    import irrigation_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o
);

    localparam int CNT_W = ptrWidth(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Run-length counter: saturates at DEBOUNCE, any clean sample restarts it.
    always_comb begin
        count_d = '0;
        if (raw_i) begin
            count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stable_o = (count_q == CNT_MAX);

endmodule

// File: rtl/irrigation_zone_sequencer.sv
// ---------------------------------------------------------------------------
// irrigation_zone_sequencer
// Waters ZONES zones one at a time in round-robin order, each for at most
// WATER_CYCLES cycles per visit, through either the shared sprinkler pump or
// the dripper path. Also runs the tank refill valve with hysteresis and a
// latched sensor-fault alarm that needs an operator acknowledge.
//
// Optional build macro:
//   IRRIG_HOLDOFF_EN - per-zone lockout of HOLDOFF_CYCLES after a visit that
//                      ran to its full watering time.
//
// Ports (all outputs registered, reset to 0):
//   clk                    in  system clock
//   rst_n                  in  asynchronous active-low reset
//   low/mid/high_water_level_i in tank level marks (1 = water above mark)
//   earth_humidity_i       in  per-zone soil wet flag (0 = needs water)
//   air_humidity_i         in  humid air, forbids sprinkler
//   low_temperature_i      in  cold, forbids sprinkler
//   alarm_ack_i            in  operator acknowledge pulse
//   water_supply_valvule_o out tank refill valve
//   alarm_o                out fault or critical tank level
//   splinker_bomb_o        out sprinkler pump enable
//   dripper_valvule_o      out dripper main valve
//   zone_valve_o           out one-hot valve of the zone being watered
//   active_zone_o          out round-robin pointer
// ---------------------------------------------------------------------------
module irrigation_zone_sequencer
    import irrigation_pkg::*;
#(
    parameter int ZONES          = 4,
    parameter int WATER_CYCLES   = 1000,
    parameter int DEBOUNCE       = 4,
    parameter int TIMER_W        = 16,
    parameter int HOLDOFF_CYCLES = 5000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         low_water_level_i,
    input  logic                         mid_water_level_i,
    input  logic                         high_water_level_i,
    input  logic [ZONES-1:0]             earth_humidity_i,
    input  logic                         air_humidity_i,
    input  logic                         low_temperature_i,
    input  logic                         alarm_ack_i,
    output logic                         water_supply_valvule_o,
    output logic                         alarm_o,
    output logic                         splinker_bomb_o,
    output logic                         dripper_valvule_o,
    output logic [ZONES-1:0]             zone_valve_o,
    output logic [ptrWidth(ZONES)-1:0]   active_zone_o
);

    localparam int PTR_W = ptrWidth(ZONES);
    localparam int CNT_W = ptrWidth(ZONES + 1);
    localparam logic [PTR_W-1:0]   LAST_ZONE  = PTR_W'(ZONES - 1);
    localparam logic [CNT_W-1:0]   LAST_SCAN  = CNT_W'(ZONES - 1);
    localparam logic [TIMER_W-1:0] WATER_LOAD = TIMER_W'(WATER_CYCLES - 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   scanCount_q, scanCount_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    mode_e              mode_q, mode_d;
    logic [ZONES-1:0]   zoneValve_q, zoneValve_d;
    logic               sprinkler_q, sprinkler_d;
    logic               dripper_q, dripper_d;
    logic               refill_q, refill_d;
    logic               alarm_q, alarm_d;

    logic               rawConflictNow;
    logic               conflictDb;
    logic               zoneHeld;
    logic               zoneDry;
    logic               timedOut;
    logic               visitDone;
    logic [PTR_W-1:0]   ptrNext;

    assign rawConflictNow = rawConflict(low_water_level_i, mid_water_level_i, high_water_level_i);

    sensor_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_conflictDebouncer (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_i    (rawConflictNow),
        .stable_o (conflictDb)
    );

`ifdef IRRIG_HOLDOFF_EN
    logic [TIMER_W-1:0] holdoff_q [ZONES];
    logic [TIMER_W-1:0] holdoff_d [ZONES];

    assign zoneHeld = (holdoff_q[ptr_q] != '0);
`else
    logic unusedHoldoff;

    assign zoneHeld      = 1'b0;
    assign unusedHoldoff = ^TIMER_W'(HOLDOFF_CYCLES);
`endif

    // With one zone the wrap lands back on zone 0.
    assign ptrNext   = (ptr_q == LAST_ZONE) ? '0 : ptr_q + PTR_W'(1);
    assign zoneDry   = ~earth_humidity_i[ptr_q] & ~zoneHeld;
    assign timedOut  = (timer_q == '0);
    assign visitDone = timedOut | earth_humidity_i[ptr_q] | ~low_water_level_i;

    // Next-state logic. A debounced sensor conflict overrides every other
    // transition; the actuator values are derived from the next state so
    // they change together with it.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        scanCount_d = scanCount_q;
        timer_d     = timer_q;
        mode_d      = mode_q;
`ifdef IRRIG_HOLDOFF_EN
        for (int z = 0; z < ZONES; z++) begin
            holdoff_d[z] = (holdoff_q[z] != '0) ? holdoff_q[z] - TIMER_W'(1) : '0;
        end
`endif

        if (conflictDb) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (low_water_level_i) begin
                        state_d     = SCAN;
                        scanCount_d = '0;
                    end
                end
                SCAN: begin
                    if (!low_water_level_i) begin
                        state_d = IDLE;
                    end else if (zoneDry) begin
                        state_d = WATER;
                        timer_d = WATER_LOAD;
                        mode_d  = (~air_humidity_i & ~low_temperature_i & mid_water_level_i)
                                  ? SPRINKLER : DRIPPER;
                    end else begin
                        ptr_d = ptrNext;
                        if (scanCount_q == LAST_SCAN) begin
                            state_d     = IDLE;
                            scanCount_d = '0;
                        end else begin
                            scanCount_d = scanCount_q + CNT_W'(1);
                        end
                    end
                end
                WATER: begin
                    if (visitDone) begin
                        state_d     = SCAN;
                        scanCount_d = '0;
                        ptr_d       = ptrNext;
`ifdef IRRIG_HOLDOFF_EN
                        if (timedOut) begin
                            holdoff_d[ptr_q] = TIMER_W'(HOLDOFF_CYCLES);
                        end
`endif
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                FAULT: begin
                    if (alarm_ack_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        zoneValve_d = '0;
        sprinkler_d = 1'b0;
        dripper_d   = 1'b0;
        if (state_d == WATER) begin
            zoneValve_d = ZONES'(1) << ptr_d;
            sprinkler_d = (mode_d == SPRINKLER);
            dripper_d   = (mode_d == DRIPPER);
        end

        // Refill hysteresis: open below mid, close at high; closing wins.
        refill_d = refill_q;
        if (state_d == FAULT) begin
            refill_d = 1'b0;
        end else if (high_water_level_i) begin
            refill_d = 1'b0;
        end else if (!mid_water_level_i) begin
            refill_d = 1'b1;
        end

        alarm_d = (state_d == FAULT) | ~low_water_level_i;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            scanCount_q <= '0;
            timer_q     <= '0;
            mode_q      <= DRIPPER;
            zoneValve_q <= '0;
            sprinkler_q <= 1'b0;
            dripper_q   <= 1'b0;
            refill_q    <= 1'b0;
            alarm_q     <= 1'b0;
`ifdef IRRIG_HOLDOFF_EN
            for (int z = 0; z < ZONES; z++) begin
                holdoff_q[z] <= '0;
            end
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            scanCount_q <= scanCount_d;
            timer_q     <= timer_d;
            mode_q      <= mode_d;
            zoneValve_q <= zoneValve_d;
            sprinkler_q <= sprinkler_d;
            dripper_q   <= dripper_d;
            refill_q    <= refill_d;
            alarm_q     <= alarm_d;
`ifdef IRRIG_HOLDOFF_EN
            for (int z = 0; z < ZONES; z++) begin
                holdoff_q[z] <= holdoff_d[z];
            end
`endif
        end
    end

    assign water_supply_valvule_o = refill_q;
    assign alarm_o                = alarm_q;
    assign splinker_bomb_o        = sprinkler_q;
    assign dripper_valvule_o      = dripper_q;
    assign zone_valve_o           = zoneValve_q;
    assign active_zone_o          = ptr_q;

endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irrigation_zone_sequencer
// Self-checking bench: a constant refill/alarm table, hand-written sequences
// for watering, debounce, faults and reset, and a randomized run compared
// every cycle against a behavioural model of the sequencer.
// ---------------------------------------------------------------------------
module tb_irrigation_zone_sequencer;

    localparam int ZONES = 4;
    localparam int WC    = 20;
    localparam int DB    = 4;
    localparam int TW    = 16;
    localparam int HO    = 40;

    localparam int P_IDLE  = 0;
    localparam int P_SCAN  = 1;
    localparam int P_WATER = 2;
    localparam int P_FAULT = 3;

    logic             clk;
    logic             rst_n;
    logic             lowL, midL, highL;
    logic [ZONES-1:0] earth;
    logic             air, lowT, ack;
    logic             refill, alarm, spl, drip;
    logic [ZONES-1:0] zoneValve;
    logic [1:0]       activeZone;

    irrigation_zone_sequencer #(
        .ZONES          (ZONES),
        .WATER_CYCLES   (WC),
        .DEBOUNCE       (DB),
        .TIMER_W        (TW),
        .HOLDOFF_CYCLES (HO)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .low_water_level_i      (lowL),
        .mid_water_level_i      (midL),
        .high_water_level_i     (highL),
        .earth_humidity_i       (earth),
        .air_humidity_i         (air),
        .low_temperature_i      (lowT),
        .alarm_ack_i            (ack),
        .water_supply_valvule_o (refill),
        .alarm_o                (alarm),
        .splinker_bomb_o        (spl),
        .dripper_valvule_o      (drip),
        .zone_valve_o           (zoneValve),
        .active_zone_o          (activeZone)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state: phase, length of the current conflict run,
    // cycles of watering left, and per-zone earliest edge it may water again.
    int mPhase, mRun, mPtr, mChecked, mLeft, edgeNum;
    bit mSprinkle, mRefill, mAlarm;
    int holdUntil[ZONES];

    typedef struct {
        logic low, mid, high;
        logic expRefill, expAlarm;
    } vec_t;
    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic m, input logic h,
                                 input logic [ZONES-1:0] e, input logic a,
                                 input logic t, input logic k);
        lowL = l; midL = m; highL = h; earth = e; air = a; lowT = t; ack = k;
    endtask

    task automatic modelReset();
        mPhase = P_IDLE; mRun = 0; mPtr = 0; mChecked = 0; mLeft = 0; edgeNum = 0;
        mSprinkle = 0; mRefill = 0; mAlarm = 0;
        for (int z = 0; z < ZONES; z++) holdUntil[z] = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs held now.
    task automatic modelStep();
        bit raw, dbNow;
        edgeNum++;
        raw   = (highL && !midL) || (midL && !lowL);
        dbNow = (mRun >= DB);
        mRun  = raw ? mRun + 1 : 0;
        if (dbNow) begin
            mPhase = P_FAULT;
        end else if (mPhase == P_IDLE) begin
            if (lowL) begin mPhase = P_SCAN; mChecked = 0; end
        end else if (mPhase == P_SCAN) begin
            if (!lowL) mPhase = P_IDLE;
            else if (!earth[mPtr] && edgeNum >= holdUntil[mPtr]) begin
                mPhase    = P_WATER;
                mLeft     = WC;
                mSprinkle = !air && !lowT && midL;
            end else begin
                mPtr = (mPtr + 1) % ZONES;
                mChecked++;
                if (mChecked == ZONES) mPhase = P_IDLE;
            end
        end else if (mPhase == P_WATER) begin
            mLeft--;
            if (mLeft == 0 || earth[mPtr] || !lowL) begin
`ifdef IRRIG_HOLDOFF_EN
                if (mLeft == 0) holdUntil[mPtr] = edgeNum + HO + 1;
`endif
                mPtr     = (mPtr + 1) % ZONES;
                mPhase   = P_SCAN;
                mChecked = 0;
            end
        end else begin
            if (ack) mPhase = P_IDLE;
        end
        if (mPhase == P_FAULT) mRefill = 0;
        else if (highL) mRefill = 0;
        else if (!midL) mRefill = 1;
        mAlarm = (mPhase == P_FAULT) || !lowL;
    endtask

    task automatic checkModel();
        logic [ZONES-1:0] ez;
        logic [31:0] act, exp;
        ez  = (mPhase == P_WATER) ? (4'b0001 << mPtr) : 4'b0000;
        exp = {22'd0, ez, (mPhase == P_WATER) && mSprinkle, (mPhase == P_WATER) && !mSprinkle,
               mRefill, mAlarm, 2'(mPtr)};
        act = {22'd0, zoneValve, spl, drip, refill, alarm, activeZone};
        checkOutput("model", act, exp);
    endtask

    // Advance one cycle: model follows the edge, outputs checked at negedge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) modelReset();
        else modelStep();
        @(negedge clk);
        checkModel();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic waitValve(input logic [ZONES-1:0] target, input int bound, output int n);
        n = 0;
        while (zoneValve !== target && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, dur, gap, hold;
        logic [2:0] lv;

        vecs[0] = '{1, 1, 1, 0, 0};
        vecs[1] = '{1, 0, 0, 1, 0};
        vecs[2] = '{1, 1, 0, 1, 0};
        vecs[3] = '{1, 1, 1, 0, 0};
        vecs[4] = '{1, 1, 0, 0, 0};
        vecs[5] = '{0, 0, 0, 1, 1};
        vecs[6] = '{0, 0, 1, 0, 1};
        vecs[7] = '{1, 0, 0, 1, 0};
        vecs[8] = '{1, 1, 1, 0, 0};

        rst_n = 1'b0;
        applyStimulus(0, 0, 0, '1, 0, 0, 0);
        modelReset();
        #1;
        checkOutput("reset outputs", {zoneValve, spl, drip, refill, alarm, activeZone}, 0);
        @(negedge clk);
        doReset();

        // Refill hysteresis and alarm table, all zones wet.
        applyStimulus(1, 1, 1, 4'hF, 0, 0, 0);
        tick();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].low, vecs[i].mid, vecs[i].high, 4'hF, 0, 0, 0);
            tick();
            checkOutput($sformatf("table refill %0d", i), refill, vecs[i].expRefill);
            checkOutput($sformatf("table alarm %0d", i), alarm, vecs[i].expAlarm);
            checkOutput($sformatf("table valve %0d", i), zoneValve, 0);
        end

        // Only zone 3 dry, sprinkler allowed.
        doReset();
        applyStimulus(1, 1, 1, 4'b0111, 0, 0, 0);
        waitValve(4'b1000, 30, n);
        checkOutput("A scan cycles", n, 5);
        checkOutput("A valve", zoneValve, 4'b1000);
        checkOutput("A sprinkler", {spl, drip}, 2'b10);
        dur = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (zoneValve === 4'b1000) dur++;
            else break;
        end
        checkOutput("A duration", dur, WC);
        checkOutput("A ptr wrap", activeZone, 0);
        checkOutput("A pump off", spl, 0);

        // Asynchronous reset while zone 2 waters.
        doReset();
        applyStimulus(1, 1, 1, 4'b1011, 0, 0, 0);
        waitValve(4'b0100, 30, n);
        checkOutput("R valve on", zoneValve, 4'b0100);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("R async clear", {zoneValve, spl, drip, refill, alarm, activeZone}, 0);
        tick();
        rst_n = 1'b1;
        checkOutput("R ptr", activeZone, 0);
        tick();
        checkOutput("R idle to scan", zoneValve, 0);

        // Zone 1 dry, humid air -> dripper; soil turning wet ends the visit.
        doReset();
        applyStimulus(1, 1, 1, 4'b1101, 1, 0, 0);
        waitValve(4'b0010, 30, n);
        checkOutput("B valve", zoneValve, 4'b0010);
        checkOutput("B dripper", {spl, drip}, 2'b01);
        repeat (9) tick();
        checkOutput("B still on", zoneValve, 4'b0010);
        earth = 4'hF;
        tick();
        checkOutput("B early exit", {zoneValve, drip}, 0);

        // Debounce: short conflict ignored, long one faults.
        doReset();
        applyStimulus(1, 1, 1, 4'hF, 0, 0, 0);
        tick();
        tick();
        applyStimulus(1, 0, 1, 4'hF, 0, 0, 0);
        repeat (DB - 1) tick();
        applyStimulus(1, 1, 1, 4'hF, 0, 0, 0);
        repeat (4) tick();
        checkOutput("C short pulse", alarm, 0);
        applyStimulus(1, 0, 1, 4'hF, 0, 0, 0);
        n = 0;
        while (alarm !== 1'b1 && n < 20) begin tick(); n++; end
        checkOutput("C fault alarm", alarm, 1);
        checkOutput("C fault actuators", {zoneValve, spl, drip, refill}, 0);
        ack = 1;
        tick();
        ack = 0;
        tick();
        checkOutput("C ack ignored", alarm, 1);
        applyStimulus(1, 1, 1, 4'hF, 0, 0, 0);
        tick();
        tick();
        checkOutput("C latched", alarm, 1);
        ack = 1;
        tick();
        ack = 0;
        checkOutput("C ack clears", alarm, 0);

        // Tank loses low mark during watering.
        doReset();
        applyStimulus(1, 1, 1, 4'b1110, 0, 0, 0);
        waitValve(4'b0001, 30, n);
        checkOutput("D valve", zoneValve, 4'b0001);
        applyStimulus(0, 0, 0, 4'b1110, 0, 0, 0);
        tick();
        checkOutput("D zone closed", zoneValve, 0);
        checkOutput("D alarm", alarm, 1);
        checkOutput("D refill", refill, 1);

        // Revisit gap for a permanently dry zone after a timeout.
        doReset();
        applyStimulus(1, 1, 1, 4'b1110, 0, 0, 0);
        waitValve(4'b0001, 30, n);
        waitValve(4'b0000, WC + 5, n);
        checkOutput("H valve off", zoneValve, 0);
        waitValve(4'b0001, HO + 60, gap);
`ifdef IRRIG_HOLDOFF_EN
        checkOutput("H lockout", gap > HO, 1);
`else
        checkOutput("H revisit gap", gap, 4);
`endif

        // Randomized run against the model.
        doReset();
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 9) != 0) begin
                    lv = 3'($urandom_range(0, 3));
                    lowL = (lv >= 1); midL = (lv >= 2); highL = (lv >= 3);
                end else begin
                    lv = 3'($urandom);
                    {lowL, midL, highL} = lv;
                end
                earth = 4'($urandom);
                air   = 1'($urandom);
                lowT  = 1'($urandom);
                hold  = $urandom_range(1, 8);
            end
            hold--;
            ack = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/irrigation_zone_sequencer.md
Name: irrigation_zone_sequencer

Overview:
Clocked, parametrised successor to the single-zone irrigation controller. It serves ZONES irrigation zones, one at a time, in round-robin order. Each zone is watered for a bounded time, using either the shared sprinkler pump or that zone's dripper path. The block also owns tank refill with hysteresis and a latched sensor-fault alarm, and sits at the top of the irrigation datapath, driving pump and valve actuators directly.

Parameters:
ZONES, 4, number of irrigation zones (1..16)
WATER_CYCLES, 1000, maximum clock cycles a zone stays in the watering state per visit
DEBOUNCE, 4, consecutive cycles a tank-sensor conflict must persist before it is treated as a fault
TIMER_W, 16, width of the watering/holdoff counters; must hold WATER_CYCLES and HOLDOFF_CYCLES
HOLDOFF_CYCLES, 5000, per-zone re-water lockout length; used only with IRRIG_HOLDOFF_EN

Ports:
clk  in  1  system clock
rst_n  in  1  reset
low_water_level  in  1  tank above low mark
mid_water_level  in  1  tank above mid mark
high_water_level  in  1  tank above high mark
earth_humidity  in  ZONES  per-zone soil wet flag; 0 = dry, needs water
air_humidity  in  1  humid air; sprinkler is disallowed when set
low_temperature  in  1  cold; sprinkler is disallowed when set
alarm_ack  in  1  single-cycle operator acknowledge
water_supply_valvule  out  1  tank refill valve
alarm  out  1  fault or critical-level indicator
splinker_bomb  out  1  sprinkler pump enable
dripper_valvule  out  1  dripper main valve
zone_valve  out  ZONES  one-hot zone valve; all zero when no zone is watering
active_zone  out  $clog2(ZONES) (min 1)  current round-robin pointer

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs register, reset value 0; pointer=0; FSM=IDLE.
- Conflict: raw conflict = (high & !mid) | (mid & !low). A counter increments while raw conflict=1 and clears to 0 otherwise. conflict_db asserts when the count reaches DEBOUNCE (saturates) and deasserts on the first clean cycle.
- FSM states: IDLE, SCAN, WATER, FAULT. From any state, conflict_db=1 goes to FAULT the next cycle; this has priority over every other transition.
- IDLE: if low_water_level=1, go to SCAN with scan_count=0.
- SCAN: examines zone[ptr], one zone per cycle.
  - If earth_humidity[ptr]=0 (and the zone is not held off): go to WATER, load timer=WATER_CYCLES-1, latch the mode.
  - Otherwise: ptr = (ptr+1) mod ZONES and increment scan_count. When scan_count reaches ZONES with no dry zone found, go to IDLE.
  - If low_water_level=0: go to IDLE.
- Mode latch: sprinkler = !air_humidity & !low_temperature & mid_water_level; otherwise dripper. The mode is held fixed for the whole visit.
- WATER: zone_valve=onehot(ptr); splinker_bomb=mode; dripper_valvule=!mode. Timer decrements each cycle.
  - Exit when timer==0, earth_humidity[ptr] rises, or low_water_level falls.
  - On exit: all actuators 0 in the next cycle, ptr advances with wrap, go to SCAN with scan_count=0.
- FAULT: zone_valve, splinker_bomb, dripper_valvule and water_supply_valvule forced 0. Return to IDLE only when conflict_db=0 and alarm_ack=1 in the same cycle; an ack while the conflict persists is ignored.
- Refill valve (outside FAULT): set when mid_water_level=0, cleared when high_water_level=1, held otherwise. If both conditions are true in one cycle, clear wins.
- alarm = (state==FAULT) | !low_water_level, registered.
- Latency: input change to actuator change is 1 cycle. Watering lasts at most WATER_CYCLES cycles per visit.
- ZONES=1: ptr is constant 0; a wrap returns to the same zone.

Optional Feature:
IRRIG_HOLDOFF_EN:
- Defined: each zone has a TIMER_W lockout counter, loaded with HOLDOFF_CYCLES when its WATER visit ends by timeout and decremented to 0. SCAN treats a nonzero-lockout zone as wet. Early exits (soil wet, water lost) do not load the lockout.
- Undefined: no lockout counters; a dry zone is eligible again on the next scan.

Decomposition:
- Package irrigation_pkg: state enum type, mode typedef (SPRINKLER/DRIPPER), ptr-width function, raw-conflict function.
- Sub-module sensor_debouncer (parameter DEBOUNCE; in: raw; out: stable flag), instanced once for the conflict signal.

Test Plan:
- Reset mid-WATER (ZONES=4, zone 2 active): assert rst_n=0 -> all outputs 0 immediately; after release, state IDLE, ptr=0.
- All wet except zone 3, low=mid=1, air_humidity=0, low_temperature=0 -> SCAN skips zones 0-2 (3 cycles), zone_valve=4'b1000, splinker_bomb=1 for exactly WATER_CYCLES cycles, then ptr=0.
- Zone 1 dry, air_humidity=1 -> dripper_valvule=1, splinker_bomb=0. Raise earth_humidity[1] after 10 cycles -> valve off the next cycle.
- Pulse high=1, mid=0 for DEBOUNCE-1 cycles -> no fault. Hold it DEBOUNCE cycles -> FAULT, alarm=1, actuators 0. Ack while conflict present -> stays in FAULT. Clear conflict, then ack -> IDLE.
- Tank drains: mid 1->0 -> water_supply_valvule=1 next cycle. high=1 -> valve 0. low=0 during WATER -> alarm=1, zone closed.
- With IRRIG_HOLDOFF_EN, ZONES=2, zone 0 permanently dry -> after a timeout, zone 0 is skipped for HOLDOFF_CYCLES cycles, then watered again.
